// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage feeding the opcode/ALUop decoder.
//
// Keeps the PC, fetches one word at a time from instruction memory over a
// req/ack handshake, and holds the returned instruction for the decoder
// until it is consumed, stalled on, or flushed by a branch redirect.
//
// Ports:
//   clock, reset        single clock; synchronous active-high reset
//   imem_req/imem_addr  fetch request and word address (held until ack)
//   imem_ack/imem_data  memory response, data valid in the ack cycle
//   stall               downstream cannot take the held instruction
//   branch_valid/target one-cycle redirect pulse and its address
//   insn, opcode, ALUop held instruction and its decoder fields
//   pc_out, insn_valid  address of held instruction, valid qualifier
//
// Optional build macro FETCH_PERF_EN adds fetch_count / stall_count
// performance counters as extra output ports.
module fetch_stage #(
    parameter int              PC_W     = 12,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_data,
    input  logic            stall,
    input  logic            branch_valid,
    input  logic [PC_W-1:0] branch_target,
    output logic [31:0]     insn,
    output logic [4:0]      opcode,
    output logic [4:0]      ALUop,
    output logic [PC_W-1:0] pc_out,
    output logic            insn_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     fetch_count,
    output logic [31:0]     stall_count
`endif
);

    typedef enum logic {FETCH, VALID} state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] tgt_q, tgt_d;      // latched redirect target
    logic            pend_q, pend_d;    // redirect waiting for the in-flight ack
    logic [31:0]     insn_q, insn_d;
    logic [PC_W-1:0] pc_out_q, pc_out_d;
    logic            capture;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        tgt_d    = tgt_q;
        pend_d   = pend_q;
        insn_d   = insn_q;
        pc_out_d = pc_out_q;
        capture  = 1'b0;
        case (state_q)
            FETCH: begin
                if (imem_ack) begin
                    if (branch_valid) begin
                        // Data belongs to the wrong path; refetch at the target.
                        pc_d   = branch_target;
                        pend_d = 1'b0;
                    end else if (pend_q) begin
                        pc_d   = tgt_q;
                        pend_d = 1'b0;
                    end else begin
                        capture  = 1'b1;
                        insn_d   = imem_data;
                        pc_out_d = pc_q;
                        state_d  = VALID;
                    end
                end else if (branch_valid) begin
                    // Request must stay stable until ack, so only remember the
                    // redirect; the latest one wins.
                    pend_d = 1'b1;
                    tgt_d  = branch_target;
                end
            end
            VALID: begin
                if (branch_valid) begin
                    pc_d    = branch_target;
                    state_d = FETCH;
                end else if (!stall) begin
                    pc_d    = pc_out_q + PC_W'(1);  // wraps modulo 2^PC_W
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            tgt_q    <= '0;
            pend_q   <= 1'b0;
            insn_q   <= '0;
            pc_out_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            tgt_q    <= tgt_d;
            pend_q   <= pend_d;
            insn_q   <= insn_d;
            pc_out_q <= pc_out_d;
        end
    end

    // Outputs are forced to zero combinationally while reset is high so the
    // very first reset cycle already shows the quiet state.
    assign imem_req   = ~reset & (state_q == FETCH);
    assign imem_addr  = reset ? '0 : pc_q;
    assign insn_valid = ~reset & (state_q == VALID);
    assign insn       = reset ? '0 : insn_q;
    assign pc_out     = reset ? '0 : pc_out_q;
    assign opcode     = insn[31:27];
    assign ALUop      = insn[6:2];

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] stall_count_q, stall_count_d;
    logic        stall_cycle;

    always_comb begin
        stall_cycle   = (state_q == VALID) & stall & ~branch_valid;
        fetch_count_d = fetch_count_q + {31'b0, capture};
        stall_count_d = stall_count_q + {31'b0, stall_cycle};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule
